// File: rtl/hx8352_bus_reader.sv
`default_nettype none
// ============================================================================
// Module      : hx8352_bus_reader
// Description : Read-side 8080-style parallel bus engine for the HX8352 panel.
//               Issues lcd_rd strobes, samples the 16-bit panel data bus at
//               the end of each low phase and streams the words back to the
//               host. Leading dummy strobes (GRAM read latency) are discarded.
// Ports       : clk, rst_n        clock, synchronous active-low reset
//               start             level input, rising edge launches a read
//               rs_sel            lcd_rs value for the transaction
//               word_count[7:0]   number of valid words to return
//               busy              transaction in progress
//               rd_data[15:0]     last captured word (held)
//               rd_valid          one-cycle pulse, rd_data updated
//               done              one-cycle pulse at transaction end
//               lcd_data_in[15:0] panel data bus input path
//               lcd_data_oe       bus drive enable (always released)
//               lcd_rs/wr/rd      panel control pins (wr held inactive)
// Revision    : 1.0 - initial release
// ============================================================================
module hx8352_bus_reader #(
   parameter int RD_LOW_CYCLES  = 4,
   parameter int RD_HIGH_CYCLES = 2,
   parameter int DUMMY_READ     = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        rs_sel,
   input  logic [7:0]  word_count,
   output logic        busy,
   output logic [15:0] rd_data,
   output logic        rd_valid,
   output logic        done,
   input  logic [15:0] lcd_data_in,
   output logic        lcd_data_oe,
   output logic        lcd_rs,
   output logic        lcd_wr,
   output logic        lcd_rd
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETUP   = 3'd1,
      S_RD_LOW  = 3'd2,
      S_RD_HIGH = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   // Phase counters are loaded with "cycles - 1" and count down to zero.
   localparam logic [15:0] c_LOW_LAST  = 16'(RD_LOW_CYCLES - 1);
   localparam logic [15:0] c_HIGH_LAST = 16'(RD_HIGH_CYCLES - 1);
   localparam logic [8:0]  c_DUMMY     = 9'(DUMMY_READ);
   localparam logic        c_HAS_DUMMY = (DUMMY_READ != 0);

   state_t      r_state;
   logic        r_start_q;
   logic [15:0] r_phase_cnt;
   // 9 bits so that word_count=255 plus one dummy strobe (256) does not wrap.
   logic [8:0]  r_pulses_left;
   logic        r_dummy_left;

   logic        w_start_edge;
   assign w_start_edge = start & ~r_start_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_start_q     <= 1'b0;
         r_phase_cnt   <= '0;
         r_pulses_left <= '0;
         r_dummy_left  <= 1'b0;
         busy          <= 1'b0;
         rd_data       <= 16'h0000;
         rd_valid      <= 1'b0;
         done          <= 1'b0;
         lcd_data_oe   <= 1'b0;
         lcd_rs        <= 1'b1;
         lcd_wr        <= 1'b1;
         lcd_rd        <= 1'b1;
      end else begin
         // Edge detector runs every cycle so edges seen while busy are consumed.
         r_start_q   <= start;
         rd_valid    <= 1'b0;
         done        <= 1'b0;
         lcd_data_oe <= 1'b0;
         lcd_wr      <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (w_start_edge) begin
                  r_pulses_left <= {1'b0, word_count} + c_DUMMY;
                  r_dummy_left  <= c_HAS_DUMMY;
                  if (word_count == 8'd0) begin
                     // Nothing to read: finish without any strobe.
                     r_state <= S_DONE;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     lcd_rs  <= 1'b1;
                  end else begin
                     r_state <= S_SETUP;
                     busy    <= 1'b1;
                     lcd_rs  <= rs_sel;
                  end
               end
            end

            S_SETUP: begin
               // One cycle of lcd_rs setup before the first strobe falls.
               r_state     <= S_RD_LOW;
               r_phase_cnt <= c_LOW_LAST;
               lcd_rd      <= 1'b0;
            end

            S_RD_LOW: begin
               if (r_phase_cnt == 16'd0) begin
                  lcd_rd        <= 1'b1;
                  r_pulses_left <= r_pulses_left - 9'd1;
                  r_state       <= S_RD_HIGH;
                  r_phase_cnt   <= c_HIGH_LAST;
                  if (r_dummy_left) begin
                     r_dummy_left <= 1'b0;
                  end else begin
                     rd_data  <= lcd_data_in;
                     rd_valid <= 1'b1;
                  end
               end else begin
                  r_phase_cnt <= r_phase_cnt - 16'd1;
               end
            end

            S_RD_HIGH: begin
               if (r_phase_cnt == 16'd0) begin
                  if (r_pulses_left != 9'd0) begin
                     r_state     <= S_RD_LOW;
                     r_phase_cnt <= c_LOW_LAST;
                     lcd_rd      <= 1'b0;
                  end else begin
                     r_state <= S_DONE;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     lcd_rs  <= 1'b1;
                  end
               end else begin
                  r_phase_cnt <= r_phase_cnt - 16'd1;
               end
            end

            S_DONE: begin
               // Start edges arriving here are dropped by design.
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
               lcd_rd  <= 1'b1;
               lcd_rs  <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hx8352_bus_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_hx8352_bus_reader
// Description : Scoreboard bench for hx8352_bus_reader. Instance A uses the
//               default timing, instance B uses 1/1 timing without dummy read.
//               Expected words are queued by the stimulus; a monitor pops and
//               compares on every rd_valid and checks strobe widths/gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hx8352_bus_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- instance A (defaults) ----------------
   logic        rst_n_a, start_a, rs_a;
   logic [7:0]  wc_a;
   logic        busy_a, valid_a, done_a, oe_a, lrs_a, lwr_a, lrd_a;
   logic [15:0] rdata_a, din_a;

   // ---------------- instance B (1/1, no dummy) ----------------
   logic        rst_n_b, start_b, rs_b;
   logic [7:0]  wc_b;
   logic        busy_b, valid_b, done_b, oe_b, lrs_b, lwr_b, lrd_b;
   logic [15:0] rdata_b, din_b;

   logic [15:0] bus_a [8];
   logic [15:0] bus_b [8];
   logic [2:0]  bus_idx [2];
   assign din_a = bus_a[bus_idx[0]];
   assign din_b = bus_b[bus_idx[1]];

   hx8352_bus_reader dut_a (
      .clk(clk), .rst_n(rst_n_a), .start(start_a), .rs_sel(rs_a), .word_count(wc_a),
      .busy(busy_a), .rd_data(rdata_a), .rd_valid(valid_a), .done(done_a),
      .lcd_data_in(din_a), .lcd_data_oe(oe_a), .lcd_rs(lrs_a), .lcd_wr(lwr_a), .lcd_rd(lrd_a)
   );

   hx8352_bus_reader #(.RD_LOW_CYCLES(1), .RD_HIGH_CYCLES(1), .DUMMY_READ(0)) dut_b (
      .clk(clk), .rst_n(rst_n_b), .start(start_b), .rs_sel(rs_b), .word_count(wc_b),
      .busy(busy_b), .rd_data(rdata_b), .rd_valid(valid_b), .done(done_b),
      .lcd_data_in(din_b), .lcd_data_oe(oe_b), .lcd_rs(lrs_b), .lcd_wr(lwr_b), .lcd_rd(lrd_b)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] q_a [$];
   logic [15:0] q_b [$];
   logic        exp_rs [2];
   int          lo_run [2];
   int          hi_run [2];
   int          strobes [2];
   int          dones [2];
   logic        hi_ok [2];
   logic        prev_rd [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One monitor step per DUT, called on every falling clock edge.
   task automatic mon_step(input int id, input logic rst, input logic rd, input logic bsy,
                           input logic rdv, input logic dn, input logic rs, input logic wr,
                           input logic oe, input logic [15:0] data, input int l_exp,
                           input int h_exp);
      logic [15:0] exp_w;
      if (!rst) begin
         lo_run[id]  = 0;
         hi_ok[id]   = 1'b0;
         prev_rd[id] = 1'b1;
         return;
      end
      if (rdv) begin
         if ((id == 0 && q_a.size() == 0) || (id == 1 && q_b.size() == 0)) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rd_valid[%0d]: got 0x%0h, expected no valid", id, data);
         end else begin
            exp_w = (id == 0) ? q_a.pop_front() : q_b.pop_front();
            check($sformatf("rd_data[%0d]", id), 32'(data), 32'(exp_w));
            check($sformatf("lcd_rs_at_valid[%0d]", id), 32'(rs), 32'(exp_rs[id]));
            check($sformatf("lcd_wr_at_valid[%0d]", id), 32'(wr), 32'd1);
            check($sformatf("lcd_oe_at_valid[%0d]", id), 32'(oe), 32'd0);
         end
      end
      if (dn) dones[id]++;
      if (rd == 1'b0) begin
         if (prev_rd[id] == 1'b1) begin
            if (hi_ok[id]) check($sformatf("rd_high_len[%0d]", id), 32'(hi_run[id]), 32'(h_exp));
            strobes[id]++;
            lo_run[id] = 0;
         end
         lo_run[id]++;
      end else begin
         if (prev_rd[id] == 1'b0) begin
            check($sformatf("rd_low_len[%0d]", id), 32'(lo_run[id]), 32'(l_exp));
            hi_run[id] = 0;
            hi_ok[id]  = 1'b1;
            bus_idx[id] = bus_idx[id] + 3'd1;
         end
         hi_run[id]++;
      end
      if (!bsy) hi_ok[id] = 1'b0;
      prev_rd[id] = rd;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         lo_run[i] = 0; hi_run[i] = 0; strobes[i] = 0; dones[i] = 0;
         hi_ok[i] = 1'b0; prev_rd[i] = 1'b1; exp_rs[i] = 1'b1; bus_idx[i] = 3'd0;
      end
      forever begin
         @(negedge clk);
         mon_step(0, rst_n_a, lrd_a, busy_a, valid_a, done_a, lrs_a, lwr_a, oe_a, rdata_a, 4, 2);
         mon_step(1, rst_n_b, lrd_b, busy_b, valid_b, done_b, lrs_b, lwr_b, oe_b, rdata_b, 1, 1);
      end
   end

   task automatic wait_done(input int id, input int max_cyc);
      logic dn, bsy, rs;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         dn  = (id == 0) ? done_a : done_b;
         bsy = (id == 0) ? busy_a : busy_b;
         rs  = (id == 0) ? lrs_a  : lrs_b;
         if (dn) begin
            check($sformatf("busy_in_done[%0d]", id), 32'(bsy), 32'd0);
            check($sformatf("rs_in_done[%0d]", id), 32'(rs), 32'd1);
            return;
         end
      end
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout[%0d]: got no done, expected done within %0d cycles", id, max_cyc);
   endtask

   int d0, s0;

   initial begin
      rst_n_a = 1'b0; start_a = 1'b0; rs_a = 1'b1; wc_a = 8'd0;
      rst_n_b = 1'b0; start_b = 1'b0; rs_b = 1'b1; wc_b = 8'd0;
      for (int i = 0; i < 8; i++) begin bus_a[i] = 16'h0; bus_b[i] = 16'h0; end
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_lcd_rd", 32'(lrd_a), 32'd1);
      check("rst_lcd_wr", 32'(lwr_a), 32'd1);
      check("rst_lcd_rs", 32'(lrs_a), 32'd1);
      check("rst_oe", 32'(oe_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_valid_done", 32'({valid_a, done_a}), 32'd0);
      check("rst_rd_data", 32'(rdata_a), 32'h0);
      check("rst_rd_data_b", 32'(rdata_b), 32'h0);
      rst_n_a = 1'b1; rst_n_b = 1'b1;
      @(negedge clk);

      // Test 1: one word with one dummy strobe
      bus_a[0] = 16'hDEAD; bus_a[1] = 16'hA5A5; bus_idx[0] = 3'd0;
      q_a.push_back(16'hA5A5);
      exp_rs[0] = 1'b1;
      s0 = strobes[0]; d0 = dones[0];
      rs_a = 1'b1; wc_a = 8'd1; start_a = 1'b1;
      @(negedge clk);
      check("t1_busy_setup", 32'(busy_a), 32'd1);
      check("t1_rd_setup", 32'(lrd_a), 32'd1);
      @(negedge clk);
      check("t1_rd_low_latency", 32'(lrd_a), 32'd0);
      start_a = 1'b0;
      wait_done(0, 100);
      @(negedge clk);
      check("t1_strobes", 32'(strobes[0] - s0), 32'd2);
      check("t1_dones", 32'(dones[0] - d0), 32'd1);
      check("t1_busy_after", 32'(busy_a), 32'd0);
      check("t1_q_empty", 32'(q_a.size()), 32'd0);

      // Test 2: three words
      bus_a[0] = 16'h0000; bus_a[1] = 16'h1111; bus_a[2] = 16'h2222; bus_a[3] = 16'h3333;
      bus_idx[0] = 3'd0;
      q_a.push_back(16'h1111); q_a.push_back(16'h2222); q_a.push_back(16'h3333);
      s0 = strobes[0];
      wc_a = 8'd3; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wait_done(0, 200);
      @(negedge clk);
      check("t2_strobes", 32'(strobes[0] - s0), 32'd4);
      check("t2_q_empty", 32'(q_a.size()), 32'd0);
      check("t2_rd_data_held", 32'(rdata_a), 32'h3333);

      // Test 3: zero words -> immediate done, no strobe
      s0 = strobes[0]; d0 = dones[0];
      wc_a = 8'd0; start_a = 1'b1;
      @(negedge clk);
      check("t3_done", 32'(done_a), 32'd1);
      check("t3_busy", 32'(busy_a), 32'd0);
      check("t3_rd", 32'(lrd_a), 32'd1);
      start_a = 1'b0;
      repeat (3) @(negedge clk);
      check("t3_no_strobe", 32'(strobes[0] - s0), 32'd0);
      check("t3_one_done", 32'(dones[0] - d0), 32'd1);

      // Test 4: long start level with a stray edge mid-transfer, then retrigger
      bus_a[0] = 16'h0BAD; bus_a[1] = 16'h1234; bus_a[2] = 16'h0BAD; bus_a[3] = 16'h5678;
      bus_idx[0] = 3'd0;
      q_a.push_back(16'h1234); q_a.push_back(16'h5678);
      s0 = strobes[0]; d0 = dones[0];
      wc_a = 8'd1; start_a = 1'b1;
      repeat (10) @(negedge clk);
      start_a = 1'b0;
      wc_a = 8'd7; rs_a = 1'b0;          // changes while busy must be ignored
      @(negedge clk);
      start_a = 1'b1;
      repeat (39) @(negedge clk);
      check("t4_one_txn_done", 32'(dones[0] - d0), 32'd1);
      check("t4_one_txn_strobes", 32'(strobes[0] - s0), 32'd2);
      start_a = 1'b0; wc_a = 8'd1; rs_a = 1'b1;
      @(negedge clk);
      start_a = 1'b1;
      wait_done(0, 100);
      start_a = 1'b0;
      @(negedge clk);
      check("t4_retrigger_done", 32'(dones[0] - d0), 32'd2);
      check("t4_retrigger_strobes", 32'(strobes[0] - s0), 32'd4);
      check("t4_q_empty", 32'(q_a.size()), 32'd0);

      // Test 5: reset during the second low cycle
      bus_idx[0] = 3'd0;
      d0 = dones[0];
      wc_a = 8'd3; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      @(negedge clk);
      check("t5_first_low", 32'(lrd_a), 32'd0);
      @(negedge clk);
      rst_n_a = 1'b0;
      @(negedge clk);
      check("t5_rd_released", 32'(lrd_a), 32'd1);
      check("t5_busy_cleared", 32'(busy_a), 32'd0);
      check("t5_no_valid", 32'(valid_a), 32'd0);
      check("t5_no_done", 32'(done_a), 32'd0);
      @(negedge clk);
      rst_n_a = 1'b1;
      repeat (20) @(negedge clk);
      check("t5_no_done_after", 32'(dones[0] - d0), 32'd0);
      check("t5_idle_rd", 32'(lrd_a), 32'd1);

      // Test 6: instance B, no dummy, single-cycle phases, rs_sel=0
      bus_b[0] = 16'hBEEF; bus_b[1] = 16'hCAFE; bus_idx[1] = 3'd0;
      q_b.push_back(16'hBEEF); q_b.push_back(16'hCAFE);
      exp_rs[1] = 1'b0;
      s0 = strobes[1];
      rs_b = 1'b0; wc_b = 8'd2; start_b = 1'b1;
      @(negedge clk);
      check("t6_rs_driven", 32'(lrs_b), 32'd0);
      @(negedge clk);
      check("t6_rd_low_latency", 32'(lrd_b), 32'd0);
      start_b = 1'b0;
      wait_done(1, 50);
      @(negedge clk);
      check("t6_strobes", 32'(strobes[1] - s0), 32'd2);
      check("t6_q_empty", 32'(q_b.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
